// File: rtl/ex_hazard_sequencer.sv
// ex_hazard_sequencer: EX-stage forwarding, load-use, flush and multi-cycle hold.
// Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module ex_hazard_sequencer #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_wb_reg_file,
  input  logic       id_is_load,
  input  logic       id_is_multicycle,
  input  logic       ex_jump_en,
  input  logic       mc_done,
  output logic [1:0] operand_a_forward_cntl,
  output logic [1:0] operand_b_forward_cntl,
  output logic       stall_if_id,
  output logic       bubble_id_ex,
  output logic       hold_ex,
  output logic       pipeline_flush,
  output logic       mc_start
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [4:0] rd;
    logic       wb_en;
    logic       is_load;
  } shadow_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_MC_WAIT
  } state_t;

  localparam logic [1:0] FWD_ORG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  state_t      state_q;
  logic        mc_start_q;
  logic [1:0]  fcnt_q;
  logic [31:0] tcnt_q;

  shadow_t     ex_q;
  shadow_t     mem_q;
  shadow_t     wb_q;
  shadow_t     ex_d;
  logic [1:0]  fwd_a_q;
  logic [1:0]  fwd_b_q;

  logic        in_run;
  logic        jump_acc;
  logic        load_use;
  logic        flush;
  logic        hold;
  logic        advance;
  logic        mc_go;
  logic        rd_hit;

  // The WB shadow only records what retires; nothing downstream reads it.
  logic        unused_shadow;
  assign unused_shadow = ^{wb_q, mem_q.is_load};

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input shadow_t    ex,
    input shadow_t    mem
  );
    logic [1:0] sel;
    sel = FWD_ORG;
    if (rs == 5'd0) begin
      sel = FWD_ORG;
    end else if (ex.wb_en && ex.rd == rs && !ex.is_load) begin
      sel = FWD_MEM;
    end else if (mem.wb_en && mem.rd == rs) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign in_run   = (state_q == S_RUN);
  assign rd_hit   = (ex_q.rd == id_rs1) || (ex_q.rd == id_rs2);

  assign jump_acc = !rst && in_run && ex_jump_en;

  assign load_use = !rst && in_run && !ex_jump_en &&
                    id_valid && ex_q.is_load &&
                    ex_q.wb_en && (ex_q.rd != 5'd0) &&
                    rd_hit;

  assign flush    = jump_acc ||
                    (!rst && state_q == S_FLUSH);
  assign hold     = !rst && (state_q == S_MC_WAIT);
  assign advance  = (state_q != S_MC_WAIT);

  assign mc_go    = in_run && id_valid &&
                    id_is_multicycle &&
                    !load_use && !ex_jump_en;

  assign ex_d.rd      = id_rd;
  assign ex_d.wb_en   = id_valid && id_wb_reg_file &&
                        !load_use && !flush;
  assign ex_d.is_load = id_valid && id_is_load &&
                        !load_use && !flush;

  assign stall_if_id            = load_use || hold;
  assign bubble_id_ex           = load_use;
  assign hold_ex                = hold;
  assign pipeline_flush         = flush;
  assign mc_start               = mc_start_q && !rst;
  assign operand_a_forward_cntl = fwd_a_q;
  assign operand_b_forward_cntl = fwd_b_q;

  // Shift the dest-reg shadows and latch forwarding as ID moves into EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_ORG;
      fwd_b_q <= FWD_ORG;
    end else if (advance) begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_sel(id_rs1, ex_q, mem_q);
      fwd_b_q <= fwd_sel(id_rs2, ex_q, mem_q);
    end
  end

  // Sequencer: RUN, multi-cycle flush window, multi-cycle EX wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      mc_start_q <= 1'b0;
      fcnt_q     <= 2'd0;
      tcnt_q     <= 32'd0;
    end else begin
      mc_start_q <= 1'b0;
      unique case (state_q)
        S_RUN: begin
          if (jump_acc) begin
            if (FLUSH_CYCLES > 1) begin
              state_q <= S_FLUSH;
              fcnt_q  <= 2'd1;
            end
          end else if (mc_go) begin
            state_q    <= S_MC_WAIT;
            mc_start_q <= 1'b1;
            tcnt_q     <= 32'd0;
          end
        end
        S_FLUSH: begin
          if (fcnt_q == 2'(FLUSH_CYCLES - 1)) begin
            state_q <= S_RUN;
            fcnt_q  <= 2'd0;
          end else begin
            fcnt_q <= fcnt_q + 2'd1;
          end
        end
        S_MC_WAIT: begin
          // mc_done in the start-pulse cycle belongs to nothing.
          if (!mc_start_q && mc_done) begin
            state_q <= S_RUN;
          end else if (MC_TIMEOUT != 0 &&
                       tcnt_q == 32'(MC_TIMEOUT - 1)) begin
            state_q <= S_RUN;
          end else begin
            tcnt_q <= tcnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Free-running stall-cycle and accepted-redirect counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_if_id) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (jump_acc) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// tb_ex_hazard_sequencer: directed checks of forwarding, hazards,
// flush and multi-cycle sequencing.
module tb_ex_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_wb_reg_file;
  logic       id_is_load;
  logic       id_is_multicycle;
  logic       ex_jump_en;
  logic       mc_done;
  logic [1:0] fa;
  logic [1:0] fb;
  logic       stall;
  logic       bubble;
  logic       hold;
  logic       flush;
  logic       mcs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] psc;
  logic [31:0] pfc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_hazard_sequencer #(
    .FLUSH_CYCLES(2),
    .MC_TIMEOUT  (8)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .id_valid              (id_valid),
    .id_rs1                (id_rs1),
    .id_rs2                (id_rs2),
    .id_rd                 (id_rd),
    .id_wb_reg_file        (id_wb_reg_file),
    .id_is_load            (id_is_load),
    .id_is_multicycle      (id_is_multicycle),
    .ex_jump_en            (ex_jump_en),
    .mc_done               (mc_done),
    .operand_a_forward_cntl(fa),
    .operand_b_forward_cntl(fb),
    .stall_if_id           (stall),
    .bubble_id_ex          (bubble),
    .hold_ex               (hold),
    .pipeline_flush        (flush),
    .mc_start              (mcs)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt        (psc),
    .perf_flush_cnt        (pfc)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int r1, input int r2,
                       input int rd, input int wb, input int ld,
                       input int mc);
    id_valid         = (v != 0);
    id_rs1           = 5'(r1);
    id_rs2           = 5'(r2);
    id_rd            = 5'(rd);
    id_wb_reg_file   = (wb != 0);
    id_is_load       = (ld != 0);
    id_is_multicycle = (mc != 0);
  endtask

  task automatic drain;
    drive(0, 0, 0, 0, 0, 0, 0);
    ex_jump_en = 1'b0;
    mc_done    = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    ex_jump_en = 1'b0;
    mc_done    = 1'b0;
    tick();
    tick();
    ex_jump_en = 1'b1;
    #1;
    total++; if (flush !== 1'b0) begin bad++;
      $display("FAIL rst_flush got=%b exp=0", flush); end
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (bubble !== 1'b0) begin bad++;
      $display("FAIL rst_bubble got=%b exp=0", bubble); end
    total++; if (hold !== 1'b0) begin bad++;
      $display("FAIL rst_hold got=%b exp=0", hold); end
    total++; if (mcs !== 1'b0) begin bad++;
      $display("FAIL rst_mcstart got=%b exp=0", mcs); end
    total++; if (fa !== 2'b00) begin bad++;
      $display("FAIL rst_fwd_a got=%b exp=00", fa); end
    total++; if (fb !== 2'b00) begin bad++;
      $display("FAIL rst_fwd_b got=%b exp=00", fb); end
    ex_jump_en = 1'b0;
    rst = 1'b0;
    tick();
    total++; if (flush !== 1'b0) begin bad++;
      $display("FAIL post_rst_flush got=%b exp=0", flush); end
  endtask

  task automatic test_fwd_mem;
    drain();
    drive(1, 1, 2, 5, 1, 0, 0);
    tick();
    drive(1, 5, 3, 8, 1, 0, 0);
    #1;
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL alu_nostall got=%b exp=0", stall); end
    tick();
    total++; if (fa !== 2'b01) begin bad++;
      $display("FAIL mem_fwd_a got=%b exp=01", fa); end
    total++; if (fb !== 2'b00) begin bad++;
      $display("FAIL mem_fwd_b got=%b exp=00", fb); end
    drive(1, 3, 5, 9, 1, 0, 0);
    tick();
    total++; if (fa !== 2'b00) begin bad++;
      $display("FAIL wb_fwd_a got=%b exp=00", fa); end
    total++; if (fb !== 2'b10) begin bad++;
      $display("FAIL wb_fwd_b got=%b exp=10", fb); end
  endtask

  task automatic test_x0_and_priority;
    drain();
    drive(1, 1, 2, 0, 1, 0, 0);
    tick();
    drive(1, 0, 0, 3, 1, 0, 0);
    tick();
    total++; if (fa !== 2'b00) begin bad++;
      $display("FAIL x0_fwd_a got=%b exp=00", fa); end
    total++; if (fb !== 2'b00) begin bad++;
      $display("FAIL x0_fwd_b got=%b exp=00", fb); end
    drain();
    drive(1, 1, 2, 0, 1, 1, 0);
    tick();
    drive(1, 0, 4, 3, 1, 0, 0);
    #1;
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL x0_load_nostall got=%b exp=0", stall); end
    drain();
    drive(1, 1, 2, 7, 1, 0, 0);
    tick();
    drive(1, 1, 2, 7, 1, 0, 0);
    tick();
    drive(1, 7, 7, 4, 1, 0, 0);
    tick();
    total++; if (fa !== 2'b01) begin bad++;
      $display("FAIL memwins_a got=%b exp=01", fa); end
    total++; if (fb !== 2'b01) begin bad++;
      $display("FAIL memwins_b got=%b exp=01", fb); end
  endtask

  task automatic test_load_use;
    drain();
    drive(1, 1, 2, 6, 1, 1, 0);
    tick();
    drive(1, 1, 6, 9, 1, 0, 0);
    #1;
    total++; if (stall !== 1'b1) begin bad++;
      $display("FAIL lu_stall got=%b exp=1", stall); end
    total++; if (bubble !== 1'b1) begin bad++;
      $display("FAIL lu_bubble got=%b exp=1", bubble); end
    tick();
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL lu_stall_once got=%b exp=0", stall); end
    total++; if (bubble !== 1'b0) begin bad++;
      $display("FAIL lu_bubble_once got=%b exp=0", bubble); end
    tick();
    total++; if (fb !== 2'b10) begin bad++;
      $display("FAIL lu_fwd_b got=%b exp=10", fb); end
    total++; if (fa !== 2'b00) begin bad++;
      $display("FAIL lu_fwd_a got=%b exp=00", fa); end
  endtask

  task automatic test_jump_load_use;
    drain();
    drive(1, 1, 2, 6, 1, 1, 0);
    tick();
    drive(1, 1, 6, 9, 1, 0, 0);
    ex_jump_en = 1'b1;
    #1;
    total++; if (flush !== 1'b1) begin bad++;
      $display("FAIL jmp_flush1 got=%b exp=1", flush); end
    total++; if (bubble !== 1'b0) begin bad++;
      $display("FAIL jmp_nobubble got=%b exp=0", bubble); end
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL jmp_nostall got=%b exp=0", stall); end
    tick();
    ex_jump_en = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (flush !== 1'b1) begin bad++;
      $display("FAIL jmp_flush2 got=%b exp=1", flush); end
    total++; if (bubble !== 1'b0) begin bad++;
      $display("FAIL jmp_flush2_bubble got=%b exp=0", bubble); end
    tick();
    total++; if (flush !== 1'b0) begin bad++;
      $display("FAIL jmp_flush_end got=%b exp=0", flush); end
  endtask

  task automatic test_mc_done;
    drain();
    drive(1, 1, 2, 10, 1, 0, 1);
    #1;
    total++; if (mcs !== 1'b0) begin bad++;
      $display("FAIL mc_early got=%b exp=0", mcs); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    mc_done = 1'b1;
    #1;
    total++; if (mcs !== 1'b1) begin bad++;
      $display("FAIL mc_start got=%b exp=1", mcs); end
    total++; if (hold !== 1'b1) begin bad++;
      $display("FAIL mc_hold1 got=%b exp=1", hold); end
    total++; if (stall !== 1'b1) begin bad++;
      $display("FAIL mc_stall1 got=%b exp=1", stall); end
    for (int i = 0; i < 4; i++) begin
      tick();
      mc_done = (i == 3);
      #1;
      total++; if (hold !== 1'b1) begin bad++;
        $display("FAIL mc_hold_c%0d got=%b exp=1", i + 2, hold); end
      total++; if (mcs !== 1'b0) begin bad++;
        $display("FAIL mc_pulse_c%0d got=%b exp=0", i + 2, mcs); end
    end
    tick();
    mc_done = 1'b0;
    #1;
    total++; if (hold !== 1'b0) begin bad++;
      $display("FAIL mc_release got=%b exp=0", hold); end
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL mc_release_stall got=%b exp=0", stall); end
  endtask

  task automatic test_mc_timeout;
    int n;
    n = 0;
    drain();
    drive(1, 1, 2, 10, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (hold === 1'b1) n++;
      tick();
    end
    total++; if (n != 8) begin bad++;
      $display("FAIL mc_timeout_cycles got=%0d exp=8", n); end
  endtask

  task automatic test_mc_reset;
    drain();
    drive(1, 1, 2, 10, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    total++; if (hold !== 1'b1) begin bad++;
      $display("FAIL mcrst_prehold got=%b exp=1", hold); end
    rst = 1'b1;
    tick();
    total++; if (hold !== 1'b0) begin bad++;
      $display("FAIL mcrst_hold got=%b exp=0", hold); end
    total++; if (stall !== 1'b0) begin bad++;
      $display("FAIL mcrst_stall got=%b exp=0", stall); end
    rst = 1'b0;
    tick();
    total++; if (hold !== 1'b0) begin bad++;
      $display("FAIL mcrst_run got=%b exp=0", hold); end
    total++; if (mcs !== 1'b0) begin bad++;
      $display("FAIL mcrst_nostart got=%b exp=0", mcs); end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf;
    drive(0, 0, 0, 0, 0, 0, 0);
    ex_jump_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    total++; if (psc !== 32'd0) begin bad++;
      $display("FAIL perf_stall_rst got=%0d exp=0", psc); end
    total++; if (pfc !== 32'd0) begin bad++;
      $display("FAIL perf_flush_rst got=%0d exp=0", pfc); end
    drive(1, 1, 2, 6, 1, 1, 0);
    tick();
    drive(1, 1, 6, 9, 1, 0, 0);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    ex_jump_en = 1'b1;
    tick();
    ex_jump_en = 1'b0;
    tick();
    tick();
    total++; if (psc !== 32'd1) begin bad++;
      $display("FAIL perf_stall got=%0d exp=1", psc); end
    total++; if (pfc !== 32'd1) begin bad++;
      $display("FAIL perf_flush got=%0d exp=1", pfc); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fwd_mem();
    test_x0_and_priority();
    test_load_use();
    test_jump_load_use();
    test_mc_done();
    test_mc_timeout();
    test_mc_reset();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
